// File: rtl/tlul_host_arb2.sv
// rtl/tlul_host_arb2.sv - two-host TL-UL arbiter sharing one in-order device port
// Optional TLUL_ARB_FIXED_PRIO_EN: host 1 always wins a tie instead of round-robin.

package tlul_host_arb2_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [15:0] a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [15:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_host_arb2
   import tlul_host_arb2_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  tl_h2d_t tl_h0_i,
   output tl_d2h_t tl_h0_o,
   input  tl_h2d_t tl_h1_i,
   output tl_d2h_t tl_h1_o,
   output tl_h2d_t tl_d_o,
   input  tl_d2h_t tl_d_i,
   output logic    spurious_o
);

   localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
   localparam int unsigned Depth = 1 << PtrW;

   logic [Depth-1:0] id_mem_q;
   logic [PtrW-1:0]  wptr_q;
   logic [PtrW-1:0]  rptr_q;
   logic [CntW-1:0]  count_q;
   logic             lock_q;
   logic             lock_id_q;

   logic gnt_any;
   logic gnt_id;
   logic gnt_a_valid;
   logic tie_id;
   logic fifo_full;
   logic fifo_empty;
   logic head_id;
   logic dev_a_valid;
   logic dev_d_ready;
   logic push;
   logic pop;

   assign fifo_full  = (count_q == CntW'(MaxOutstanding));
   assign fifo_empty = (count_q == '0);
   assign head_id    = id_mem_q[rptr_q];

`ifdef TLUL_ARB_FIXED_PRIO_EN
   assign tie_id = 1'b1;
`else
   logic rr_q;

   assign tie_id = rr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= 1'b0;
      end else if (push) begin
         rr_q <= ~gnt_id;
      end
   end
`endif

   // A held grant wins over arbitration so a stalled request cannot be swapped out.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (lock_q) begin
         gnt_any = 1'b1;
         gnt_id  = lock_id_q;
      end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
         gnt_any = 1'b1;
         gnt_id  = tie_id;
      end else if (tl_h0_i.a_valid) begin
         gnt_any = 1'b1;
         gnt_id  = 1'b0;
      end else if (tl_h1_i.a_valid) begin
         gnt_any = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   assign gnt_a_valid = gnt_any && (gnt_id ? tl_h1_i.a_valid : tl_h0_i.a_valid);
   assign dev_a_valid = rst_ni && gnt_a_valid && !fifo_full;
   // With nothing outstanding every D beat is sunk so a stray response cannot stall the device.
   assign dev_d_ready = fifo_empty ? 1'b1 : (head_id ? tl_h1_i.d_ready : tl_h0_i.d_ready);

   assign push       = dev_a_valid && tl_d_i.a_ready;
   assign pop        = !fifo_empty && tl_d_i.d_valid && dev_d_ready;
   assign spurious_o = rst_ni && fifo_empty && tl_d_i.d_valid;

   always_comb begin
      tl_d_o         = gnt_id ? tl_h1_i : tl_h0_i;
      tl_d_o.a_valid = dev_a_valid;
      tl_d_o.d_ready = dev_d_ready;

      tl_h0_o         = tl_d_i;
      tl_h0_o.a_ready = rst_ni && gnt_any && !gnt_id && tl_d_i.a_ready && !fifo_full;
      tl_h0_o.d_valid = rst_ni && !fifo_empty && !head_id && tl_d_i.d_valid;

      tl_h1_o         = tl_d_i;
      tl_h1_o.a_ready = rst_ni && gnt_any && gnt_id && tl_d_i.a_ready && !fifo_full;
      tl_h1_o.d_valid = rst_ni && !fifo_empty && head_id && tl_d_i.d_valid;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
      end else if (push) begin
         lock_q <= 1'b0;
      end else if (gnt_a_valid) begin
         lock_q    <= 1'b1;
         lock_id_q <= gnt_id;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_mem_q <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            id_mem_q[wptr_q] <= gnt_id;
            wptr_q <= (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tlul_host_arb2.sv
// tb/tb_tlul_host_arb2.sv - directed and randomized checks of tlul_host_arb2 against a queue model

module tb_tlul_host_arb2;
   import tlul_host_arb2_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n;
   tl_h2d_t h0_i, h1_i, d_o;
   tl_d2h_t h0_o, h1_o, d_i;
   logic    spurious;

   always #5 clk = ~clk;

   tlul_host_arb2 #(.MaxOutstanding(2)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .tl_h0_i    (h0_i),
      .tl_h0_o    (h0_o),
      .tl_h1_i    (h1_i),
      .tl_h1_o    (h1_o),
      .tl_d_o     (d_o),
      .tl_d_i     (d_i),
      .spurious_o (spurious)
   );

   int checks   = 0;
   int failures = 0;

   // reference model: outstanding host IDs in issue order, next tie winner, held grant
   int q[$];
   int push_log[$];
   bit rr, lock, lock_id;
   bit pend [2];
   bit auto_d;
   bit e_gv, e_g, e_dav, e_push, e_pop, e_hold;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic tl_h2d_t host(input bit h);
      return h ? h1_i : h0_i;
   endfunction

   task automatic model_clear();
      q.delete();
      rr      = 1'b0;
      lock    = 1'b0;
      lock_id = 1'b0;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
   endtask

   task automatic eval();
      bit v0, v1, full, dv, rdy;
      int head;
      if (auto_d) d_i.d_valid = (q.size() > 0);
      #1;
      v0   = h0_i.a_valid;
      v1   = h1_i.a_valid;
      full = (q.size() >= 2);
      dv   = d_i.d_valid;
      e_gv = 1'b1;
      if (lock) e_g = lock_id;
`ifdef TLUL_ARB_FIXED_PRIO_EN
      else if (v0 && v1) e_g = 1'b1;
`else
      else if (v0 && v1) e_g = rr;
`endif
      else if (v0) e_g = 1'b0;
      else if (v1) e_g = 1'b1;
      else begin
         e_gv = 1'b0;
         e_g  = 1'b0;
      end
      e_hold = e_gv && (e_g ? v1 : v0);
      e_dav  = e_hold && !full;
      e_push = e_dav && d_i.a_ready;
      chk("dev_a_valid", d_o.a_valid, e_dav);
      chk("h0_a_ready", h0_o.a_ready, e_gv && !e_g && d_i.a_ready && !full);
      chk("h1_a_ready", h1_o.a_ready, e_gv && e_g && d_i.a_ready && !full);
      if (e_dav) chk("dev_a_address", d_o.a_address, host(e_g).a_address);
      if (q.size() > 0) begin
         head = q[0];
         rdy  = (head == 1) ? h1_i.d_ready : h0_i.d_ready;
         chk("h0_d_valid", h0_o.d_valid, dv && head == 0);
         chk("h1_d_valid", h1_o.d_valid, dv && head == 1);
         chk("dev_d_ready", d_o.d_ready, rdy);
         chk("spurious_idle", spurious, 1'b0);
         if (dv) chk("routed_d_data", (head == 1) ? h1_o.d_data : h0_o.d_data, d_i.d_data);
         e_pop = dv && rdy;
      end else begin
         chk("h0_d_valid_empty", h0_o.d_valid, 1'b0);
         chk("h1_d_valid_empty", h1_o.d_valid, 1'b0);
         chk("spurious", spurious, dv);
         if (dv) chk("spurious_sink", d_o.d_ready, 1'b1);
         e_pop = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
         q.push_back(int'(e_g));
         push_log.push_back(int'(e_g));
         pend[e_g] = 1'b0;
         lock      = 1'b0;
         rr        = ~e_g;
      end else if (e_hold) begin
         lock    = 1'b1;
         lock_id = e_g;
      end
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      h0_i   = '0;
      h1_i   = '0;
      d_i    = '0;
      auto_d = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_g;
      h0_i   = '0;
      h1_i   = '0;
      d_i    = '0;
      auto_d = 1'b0;
      model_clear();

      // reset: outputs quiet even with traffic on every input
      rst_n        = 1'b0;
      h0_i.a_valid = 1'b1;
      h1_i.a_valid = 1'b1;
      d_i.a_ready  = 1'b1;
      d_i.d_valid  = 1'b1;
      #2;
      chk("rst_dev_a_valid", d_o.a_valid, 1'b0);
      chk("rst_h0_a_ready", h0_o.a_ready, 1'b0);
      chk("rst_h1_a_ready", h1_o.a_ready, 1'b0);
      chk("rst_h0_d_valid", h0_o.d_valid, 1'b0);
      chk("rst_h1_d_valid", h1_o.d_valid, 1'b0);
      chk("rst_spurious", spurious, 1'b0);
      chk("rst_count", dut.count_q, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      h0_i  = '0;
      h1_i  = '0;
      d_i   = '0;

      // single host read
      h0_i.a_valid   = 1'b1;
      h0_i.a_opcode  = 3'd4;
      h0_i.a_address = 32'h0000_0100;
      d_i.a_ready    = 1'b1;
      eval();
      chk("single_a_address", d_o.a_address, 32'h0000_0100);
      tick();
      chk("single_count_1", dut.count_q, 1);
      h0_i.a_valid = 1'b0;
      h0_i.d_ready = 1'b1;
      d_i.d_valid  = 1'b1;
      d_i.d_data   = 32'hDEAD_BEEF;
      eval();
      chk("single_d_valid", h0_o.d_valid, 1'b1);
      chk("single_d_data", h0_o.d_data, 32'hDEAD_BEEF);
      chk("single_h1_quiet", h1_o.d_valid, 1'b0);
      tick();
      chk("single_count_0", dut.count_q, 0);
      d_i.d_valid = 1'b0;

      // contention, device always ready and answering next cycle
      do_reset();
      push_log.delete();
      h0_i.a_valid   = 1'b1;
      h0_i.a_address = 32'h200;
      h1_i.a_valid   = 1'b1;
      h1_i.a_address = 32'h300;
      h0_i.d_ready   = 1'b1;
      h1_i.d_ready   = 1'b1;
      d_i.a_ready    = 1'b1;
      auto_d         = 1'b1;
      repeat (4) begin
         eval();
         tick();
      end
      h0_i.a_valid = 1'b0;
      h1_i.a_valid = 1'b0;
      repeat (2) begin
         eval();
         tick();
      end
      auto_d      = 1'b0;
      d_i.d_valid = 1'b0;
      chk("contention_beats", push_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
`ifdef TLUL_ARB_FIXED_PRIO_EN
         exp_g = 1;
`else
         exp_g = i % 2;
`endif
         chk("contention_grant", (i < push_log.size()) ? push_log[i] : 99, exp_g);
      end

      // lock: h1 stalled three cycles, h0 arrives in cycle 2
      do_reset();
      push_log.delete();
      d_i.a_ready    = 1'b0;
      h1_i.a_valid   = 1'b1;
      h1_i.a_address = 32'h400;
      eval();
      tick();
      h0_i.a_valid   = 1'b1;
      h0_i.a_address = 32'h500;
      eval();
      chk("lock_hold_c2", d_o.a_address, 32'h400);
      tick();
      eval();
      chk("lock_hold_c3", d_o.a_address, 32'h400);
      tick();
      d_i.a_ready = 1'b1;
      eval();
      tick();
      h1_i.a_valid = 1'b0;
      eval();
      tick();
      h0_i.a_valid = 1'b0;
      chk("lock_first", (push_log.size() > 0) ? push_log[0] : 99, 1);
      chk("lock_second", (push_log.size() > 1) ? push_log[1] : 99, 0);

      // full: two outstanding, no D
      h0_i.a_valid   = 1'b1;
      h0_i.a_address = 32'h600;
      eval();
      chk("full_a_valid", d_o.a_valid, 1'b0);
      chk("full_h0_a_ready", h0_o.a_ready, 1'b0);
      chk("full_h1_a_ready", h1_o.a_ready, 1'b0);
      tick();
      d_i.d_valid  = 1'b1;
      h1_i.d_ready = 1'b1;
      eval();
      chk("full_pop_cycle_blocked", d_o.a_valid, 1'b0);
      tick();
      d_i.d_valid = 1'b0;
      eval();
      chk("full_push_after_pop", d_o.a_valid, 1'b1);
      tick();
      h0_i.a_valid = 1'b0;

      // routing: h0 then h1 outstanding, h1 slow to accept its response
      do_reset();
      d_i.a_ready    = 1'b1;
      h0_i.a_valid   = 1'b1;
      h0_i.a_address = 32'h700;
      eval();
      tick();
      h0_i.a_valid   = 1'b0;
      h1_i.a_valid   = 1'b1;
      h1_i.a_address = 32'h800;
      eval();
      tick();
      h1_i.a_valid = 1'b0;
      d_i.d_valid  = 1'b1;
      d_i.d_data   = 32'h1111_1111;
      h0_i.d_ready = 1'b1;
      h1_i.d_ready = 1'b0;
      eval();
      chk("route_first_h0", h0_o.d_valid, 1'b1);
      tick();
      d_i.d_data = 32'h2222_2222;
      repeat (2) begin
         eval();
         chk("route_stall_d_ready", d_o.d_ready, 1'b0);
         chk("route_stall_h1_valid", h1_o.d_valid, 1'b1);
         tick();
      end
      h1_i.d_ready = 1'b1;
      eval();
      chk("route_second_data", h1_o.d_data, 32'h2222_2222);
      tick();
      d_i.d_valid = 1'b0;
      chk("route_drained", dut.count_q, 0);

      // spurious beat with nothing outstanding
      d_i.d_valid = 1'b1;
      eval();
      chk("spurious_pulse", spurious, 1'b1);
      chk("spurious_d_ready", d_o.d_ready, 1'b1);
      tick();
      d_i.d_valid = 1'b0;
      eval();
      chk("spurious_one_cycle", spurious, 1'b0);
      tick();

      // reset with one outstanding drops it
      h0_i.a_valid = 1'b1;
      eval();
      tick();
      h0_i.a_valid = 1'b0;
      chk("mid_count_1", dut.count_q, 1);
      rst_n = 1'b0;
      #2;
      chk("async_reset_count", dut.count_q, 0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      d_i.d_valid = 1'b1;
      eval();
      chk("post_reset_spurious", spurious, 1'b1);
      tick();
      d_i.d_valid = 1'b0;

      // randomized traffic; hosts hold a request until it is accepted
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (!pend[0]) begin
            h0_i.a_valid = 1'($urandom_range(0, 1));
            if (h0_i.a_valid) begin
               h0_i.a_address = $urandom;
               h0_i.a_data    = $urandom;
               pend[0]        = 1'b1;
            end
         end
         if (!pend[1]) begin
            h1_i.a_valid = 1'($urandom_range(0, 1));
            if (h1_i.a_valid) begin
               h1_i.a_address = $urandom;
               h1_i.a_data    = $urandom;
               pend[1]        = 1'b1;
            end
         end
         d_i.a_ready  = 1'($urandom_range(0, 1));
         h0_i.d_ready = 1'($urandom_range(0, 1));
         h1_i.d_ready = 1'($urandom_range(0, 1));
         d_i.d_data   = $urandom;
         if (q.size() > 0) d_i.d_valid = 1'($urandom_range(0, 1));
         else d_i.d_valid = ($urandom_range(0, 7) == 0);
         eval();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlul_host_arb2.md
# tlul_host_arb2

Two-host TL-UL arbiter that shares one device port between the instruction-fetch host and the LSU host. It sits between the core's two TL-UL host ports and a shared single-port device, for example ICCM reached by both fetch and LSU data accesses. It arbitrates A-channel requests, tracks outstanding transactions in a host-ID FIFO, and routes each D-channel response back to the host that issued the request. The device must respond in order.

## Interface
Parameters:
- `MaxOutstanding`, default 2: depth of the outstanding-request FIFO. Legal values 1..8.

Ports:
- `clk_i`  input  1  single clock.
- `rst_ni`  input  1  reset, asynchronous and active-low.
- `tl_h0_i`  input  `tl_h2d_t`  host 0 request (instruction fetch).
- `tl_h0_o`  output  `tl_d2h_t`  host 0 response.
- `tl_h1_i`  input  `tl_h2d_t`  host 1 request (LSU).
- `tl_h1_o`  output  `tl_d2h_t`  host 1 response.
- `tl_d_o`  output  `tl_h2d_t`  request to the shared device.
- `tl_d_i`  input  `tl_d2h_t`  response from the shared device.
- `spurious_o`  output  1  one-cycle pulse when the device sends a D beat with no request outstanding.

## Operation
- State:
  - `rr_q`: the host that has priority next. Resets to host 0.
  - `lock_q` and `lock_id_q`: grant hold.
  - `MaxOutstanding`-entry FIFO of 1-bit host IDs, with `count_q`.
- Grant selection:
  - If `lock_q` is set, the grant is `lock_id_q`.
  - Otherwise, if exactly one host has `a_valid`, that host is granted.
  - If both have `a_valid`, `rr_q` is granted.
  - If neither has `a_valid`, nothing is granted.
- A channel:
  - All `tl_d_o` A fields (opcode, address, source, size, mask, data, user) come from the granted host.
  - `tl_d_o.a_valid` is the granted host's `a_valid` AND FIFO not full.
  - The granted host's `a_ready` is `tl_d_i.a_ready` AND FIFO not full. The non-granted host's `a_ready` is 0.
- Lock: if the granted host has `a_valid`=1 and is not accepted, set `lock_q` with `lock_id_q` = that host. `lock_q` clears on that host's A handshake. This keeps requests stable, as TL-UL requires.
- A handshake (`tl_d_o.a_valid && tl_d_i.a_ready`):
  - Push the granted ID into the FIFO.
  - `rr_q` is set to the other host.
- D channel:
  - If FIFO not empty, the head ID selects the destination. That host's `d_*` fields equal `tl_d_i`, and its `d_valid` equals `tl_d_i.d_valid`. The other host gets `d_valid`=0.
  - `tl_d_o.d_ready` is the head host's `d_ready`.
  - On D handshake, pop the FIFO.
- Spurious response: FIFO empty and `tl_d_i.d_valid`=1 → `tl_d_o.d_ready`=1 (sink the beat), neither host sees `d_valid`, and `spurious_o`=1 for that cycle.
- Simultaneous push and pop: `count_q` is unchanged and the FIFO pointers both advance.
- FIFO full: pushes are blocked even if a pop happens in the same cycle, so a_ready stays 0 for that cycle.

## Timing
- The A and D paths are combinational, with zero added latency. All state updates on `posedge clk_i`.
- The device returns D no earlier than the cycle after the A handshake. A D beat for a request cannot appear in the same cycle as that request's push.
- Reset, asynchronous on `rst_ni` low:
  - State: FIFO empty, `count_q`=0, `rr_q`=0, `lock_q`=0.
  - Outputs during reset: `spurious_o`=0, both hosts' `d_valid`=0, both hosts' `a_ready`=0. `tl_d_o.a_valid` follows the grant, forced to 0 while FIFO bookkeeping is in reset.
- Reset in the middle of a transaction drops all outstanding IDs. Any later D beat is treated as spurious.
- Fairness: with both hosts continuously requesting, grants alternate every accepted beat (0, 1, 0, 1, ...).

## Configuration
- `TLUL_ARB_FIXED_PRIO_EN`:
  - Defined: host 1 (LSU) always wins a tie. `rr_q` is not implemented. Lock behaviour is unchanged.
  - Undefined (default): round-robin as described above.

## Test plan
- Single host: h0 reads 0x0000_0100, device sets `a_ready`=1 and responds next cycle → h0 receives `d_valid` with data 0xDEAD_BEEF, h1 `d_valid`=0, `count_q` goes 1→0.
- Contention: both hosts valid for 4 accepted beats, device always ready → grants in the order h0, h1, h0, h1. With `TLUL_ARB_FIXED_PRIO_EN`: h1 four times.
- Lock: h1 granted while device `a_ready`=0 for 3 cycles, h0 becomes valid in cycle 2 → grant stays h1 until accepted, then h0.
- Full: `MaxOutstanding`=2 with 2 requests outstanding and no D → both hosts' `a_ready`=0 and `tl_d_o.a_valid`=0. After one D pop, the next push happens the following cycle.
- Routing: h0 then h1 accepted, responses returned in order, h1 holds `d_ready`=0 for 2 cycles → h0 receives the first response. For the second, `tl_d_o.d_ready`=0 until h1 is ready.
- Spurious and reset: D beat with FIFO empty → `spurious_o` pulses for 1 cycle and the beat is sunk. Assert `rst_ni` with 1 outstanding, then send a D beat → `spurious_o`=1.
